// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment pattern constants, FSM encoding and helpers for the scan reader
package seg7_pkg;

  typedef logic [0:6] seg7_pat_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Index 0 of a pattern is segment a, so the literals read a..g left to right.
  localparam seg7_pat_t SEG_HEX [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  localparam seg7_pat_t SEG_BLANK = 7'b0000000;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  function automatic int onehot_index(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int k = 0; k < 32; k++) begin
      if (v[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to hex / blank classifier
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg7_pat_t  i_seg,
  output logic [3:0] o_hex,
  output logic       o_is_hex,
  output logic       o_is_blank
);

  always_comb begin
    o_hex    = 4'd0;
    o_is_hex = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (i_seg == SEG_HEX[k]) begin
        o_hex    = 4'(k);
        o_is_hex = 1'b1;
      end
    end
    o_is_blank = (i_seg == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - snoops a multiplexed 7-segment bus and recovers the hex value per digit
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int COMMON_ANODE  = 0,
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [0:6]                  seg_in,
  input  logic [N_DIGITS-1:0]         an_in,
  output logic [4*N_DIGITS-1:0]       digits,
  output logic [N_DIGITS-1:0]         digit_valid,
  output logic                        upd,
  output logic [$clog2(N_DIGITS)-1:0] upd_idx,
  output logic                        err
);

  localparam int   IDX_W = $clog2(N_DIGITS);
  localparam int   CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic INV   = (COMMON_ANODE != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  seg7_pat_t                  r_seg_q;
  logic [N_DIGITS-1:0]        r_an_q;
  logic [CNT_W-1:0]           r_cnt;
  logic [1:0]                 r_state;
  logic [N_DIGITS-1:0][3:0]   r_digits;
  logic [N_DIGITS-1:0]        r_valid;
  logic                       r_upd;
  logic [IDX_W-1:0]           r_upd_idx;
  logic                       r_err;

  seg7_pat_t                  w_seg_n;
  logic [N_DIGITS-1:0]        w_an_n;
  logic                       w_an_onehot;
  logic                       w_changed;
  logic                       w_capture;
  logic [IDX_W-1:0]           w_idx;
  logic [3:0]                 w_hex;
  logic                       w_is_hex;
  logic                       w_is_blank;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic [1:0]                 w_state_nxt;

  assign w_seg_n     = seg_in ^ {7{INV}};
  assign w_an_n      = an_in ^ {N_DIGITS{INV}};
  assign w_an_onehot = $onehot(w_an_n);
  assign w_changed   = {w_seg_n, w_an_n} != {r_seg_q, r_an_q};
  // The registered pair has been seen STABLE_CYCLES times; capture it even if the bus moves on now.
  assign w_capture   = (r_state == ST_COUNT) && (r_cnt == CNT_MAX);
  assign w_idx       = IDX_W'(onehot_index(32'(r_an_q)));

  seg7_pattern_decode u_decode (
    .i_seg      (r_seg_q),
    .o_hex      (w_hex),
    .o_is_hex   (w_is_hex),
    .o_is_blank (w_is_blank)
  );

  // Next state is judged on the pair about to be registered, so WAIT always means r_an_q is not one-hot.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!w_an_onehot) begin
      w_state_nxt = ST_WAIT;
      w_cnt_nxt   = '0;
    end else if (w_changed) begin
      w_state_nxt = ST_COUNT;
      w_cnt_nxt   = CNT_W'(1);
    end else begin
      if (w_capture) w_state_nxt = ST_LOCKED;
      if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q   <= '0;
      r_an_q    <= '0;
      r_cnt     <= '0;
      r_state   <= ST_WAIT;
      r_digits  <= '0;
      r_valid   <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
      r_err     <= 1'b0;
    end else begin
      r_seg_q <= w_seg_n;
      r_an_q  <= w_an_n;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_upd   <= w_capture;
      r_err   <= w_capture && !w_is_hex && !w_is_blank;
      if (w_capture) begin
        r_upd_idx <= w_idx;
        if (w_is_hex) begin
          r_digits[w_idx] <= w_hex;
          r_valid[w_idx]  <= 1'b1;
        end else if (w_is_blank) begin
          r_digits[w_idx] <= 4'd0;
          r_valid[w_idx]  <= 1'b0;
        end else begin
          r_valid[w_idx]  <= 1'b0;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign upd         = r_upd;
  assign upd_idx     = r_upd_idx;
  assign err         = r_err;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - scoreboard bench for seg7_scan_reader, common-cathode and common-anode instances
module tb_seg7_scan_reader;

  localparam int N = 4;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [0:6]     seg = '0;
  logic [N-1:0]   an  = '0;
  logic [0:6]     seg_ca;
  logic [N-1:0]   an_ca;
  logic [4*N-1:0] dig0, dig1;
  logic [N-1:0]   val0, val1;
  logic           upd0, upd1, err0, err1;
  logic [1:0]     idx0, idx1;

  // The common-anode instance sees the electrically inverted version of the same bus.
  assign seg_ca = ~seg;
  assign an_ca  = ~an;

  always #5 clk = ~clk;

  seg7_scan_reader #(.COMMON_ANODE(0), .N_DIGITS(N), .STABLE_CYCLES(S)) dut_cc (
    .clk(clk), .rst(rst), .seg_in(seg), .an_in(an), .digits(dig0), .digit_valid(val0),
    .upd(upd0), .upd_idx(idx0), .err(err0)
  );

  seg7_scan_reader #(.COMMON_ANODE(1), .N_DIGITS(N), .STABLE_CYCLES(S)) dut_ca (
    .clk(clk), .rst(rst), .seg_in(seg_ca), .an_in(an_ca), .digits(dig1), .digit_valid(val1),
    .upd(upd1), .upd_idx(idx1), .err(err1)
  );

  typedef struct {
    int             edge_n;
    int             idx;
    logic           err;
    logic [4*N-1:0] dig;
    logic [N-1:0]   val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  logic [6:0] tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Returns 0..15 for a hex glyph, 16 for blank, -1 for anything else.
  function automatic int classify(input logic [6:0] p);
    int r;
    r = (p == 7'b0) ? 16 : -1;
    for (int k = 0; k < 16; k++) if (tab[k] == p) r = k;
    return r;
  endfunction

  // Reference model: a one-hot pair seen S samples in a row yields one capture on the following edge.
  logic [3:0]   m_dig [N];
  logic         m_val [N];
  logic [0:6]   m_seg_prev;
  logic [N-1:0] m_an_prev;
  int           run_len;

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_dig[i] = 4'd0; m_val[i] = 1'b0; end
      m_seg_prev = '0;
      m_an_prev  = '0;
      run_len    = 0;
      q.delete();
    end else begin
      if (seg == m_seg_prev && an == m_an_prev) run_len++;
      else run_len = 1;
      m_seg_prev = seg;
      m_an_prev  = an;
      if (run_len == S && $countones(an) == 1) begin
        exp_t e;
        int   c;
        int   d;
        d = 0;
        for (int i = 0; i < N; i++) if (an[i]) d = i;
        c = classify(seg);
        if (c == 16) begin m_dig[d] = 4'd0; m_val[d] = 1'b0; end
        else if (c < 0) m_val[d] = 1'b0;
        else begin m_dig[d] = 4'(c); m_val[d] = 1'b1; end
        e.edge_n = edge_cnt + 1;
        e.idx    = d;
        e.err    = (c < 0);
        for (int i = 0; i < N; i++) begin e.dig[4*i +: 4] = m_dig[i]; e.val[i] = m_val[i]; end
        q.push_back(e);
      end
    end
  end

  // Monitor: every update pulse must match the oldest expectation, at its exact edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].edge_n <= edge_cnt) begin
      e = q.pop_front();
      chk("upd_pulse", {upd0, upd1}, 2'b11);
      chk("upd_idx", {idx0, idx1}, {2'(e.idx), 2'(e.idx)});
      chk("err", {err0, err1}, {e.err, e.err});
      chk("digits", {dig0, dig1}, {e.dig, e.dig});
      chk("digit_valid", {val0, val1}, {e.val, e.val});
    end else begin
      chk("idle_no_upd_err", {upd0, upd1, err0, err1}, 4'b0);
    end
  end

  task automatic apply(input logic [6:0] s, input logic [N-1:0] a, input int n);
    seg = s;
    an  = a;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [6:0]   rs;
    logic [N-1:0] ra;
    int           k;
    repeat (3) @(negedge clk);
    chk("reset_digits", {dig0, dig1}, '0);
    chk("reset_valid", {val0, val1}, '0);
    chk("reset_upd_err_idx", {upd0, upd1, err0, err1, idx0, idx1}, '0);
    rst = 1'b0;

    apply(7'b1111001, 4'b0100, 10);
    for (int v = 0; v < 16; v++) apply(tab[v], 4'b0001, 6);
    apply(7'b1010101, 4'b0001, 6);

    apply(7'b0110000, 4'b0001, 6);
    apply(7'b1111111, 4'b0001, 3);
    apply(7'b0110000, 4'b0001, 6);
    apply(7'b1111111, 4'b0011, 8);

    apply(7'b1111111, 4'b0001, 6);
    apply(7'b0000000, 4'b0001, 6);

    apply(7'b1011011, 4'b1000, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply(7'b1011011, 4'b1000, 8);

    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 11);
      if (k < 8) ra = 4'(1 << $urandom_range(0, N - 1));
      else if (k == 8) ra = '0;
      else ra = 4'($urandom);
      k = $urandom_range(0, 13);
      if (k < 11) rs = tab[$urandom_range(0, 15)];
      else if (k == 11) rs = 7'b0;
      else rs = 7'($urandom);
      if ($urandom_range(0, 50) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      apply(rs, ra, $urandom_range(1, 7));
    end

    apply(7'b0, '0, 8);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
